axis_word_deframer: RTL

Receive-side deframer for the 156.25 MHz socket bridge. Takes the raw, non-backpressurable stream of 64-bit words coming back from the host socket path and rebuilds AXI-Stream frames from a one-word length header, with correct `tkeep`/`tlast`. It buffers payload in an internal FIFO so a stalled `rx_axis_tready` never loses a word. Frames that cannot be buffered whole, and malformed headers, are dropped and counted.

---
 rtl/axis_word_deframer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/axis_word_deframer.sv
// Rebuilds AXI-Stream frames from a header-prefixed, non-backpressurable 64-bit word stream.
// Payload is buffered so a stalled rx_axis_tready never loses a word; unfit frames are dropped.
module axis_word_deframer #(
   parameter int          DATA_W     = 64,
   parameter int          FIFO_DEPTH = 64,
   parameter int          MAX_LEN    = 512,
   parameter logic [31:0] MAGIC      = 32'hA5A5_5A5A
) (
   input  logic              clk156,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic [DATA_W-1:0] rx_axis_tdata,
   output logic [7:0]        rx_axis_tkeep,
   output logic              rx_axis_tvalid,
   input  logic              rx_axis_tready,
   output logic              rx_axis_tlast,
   output logic [31:0]       frames_ok,
   output logic [15:0]       frames_dropped,
   output logic [15:0]       hdr_err,
   output logic [15:0]       seq_err
);

   localparam int          AW        = $clog2(FIFO_DEPTH);
   localparam int          EW        = DATA_W + 9;
   localparam logic [AW:0] DEPTH_C   = (AW+1)'(FIFO_DEPTH);
   localparam logic [31:0] DEPTH_U   = 32'(FIFO_DEPTH);
   localparam logic [15:0] MAX_LEN_U = 16'(MAX_LEN);

   typedef enum logic [1:0] {HDR, PAY, DISC} state_t;

   state_t        state;
   logic [12:0]   remaining;
   logic [2:0]    len_rem;
   logic [15:0]   exp_seq;
   logic          seq_valid;

   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [EW-1:0] head;

   logic [15:0]   hdr_len;
   logic [15:0]   hdr_seq;
   logic          hdr_bad;
   logic [12:0]   hdr_beats;
   logic [31:0]   free;
   logic          fits;
   logic          last_beat;
   logic [7:0]    last_keep;
   logic [EW-1:0] push_entry;
   logic          push;
   logic          pop;

   assign hdr_len   = in_data[15:0];
   assign hdr_seq   = in_data[31:16];
   assign hdr_bad   = (in_data[63:32] != MAGIC) || (hdr_len == 16'd0) || (hdr_len > MAX_LEN_U);
   assign hdr_beats = 13'((hdr_len + 16'd7) >> 3);
   // Free space uses the occupancy before any pop this cycle, so the reservation is conservative.
   assign free      = DEPTH_U - 32'(count);
   assign fits      = (32'(hdr_beats) <= free);

   assign last_beat  = (remaining == 13'd1);
   assign last_keep  = (len_rem == 3'd0) ? 8'hFF : ((8'h01 << len_rem) - 8'h01);
   assign push_entry = {in_data, (last_beat ? last_keep : 8'hFF), last_beat};
   assign push       = (state == PAY) && in_valid;
   assign pop        = rx_axis_tvalid && rx_axis_tready;

   assign head           = mem[rd_ptr];
   assign rx_axis_tvalid = (count != '0);
   assign rx_axis_tdata  = rx_axis_tvalid ? head[EW-1 -: DATA_W] : '0;
   assign rx_axis_tkeep  = rx_axis_tvalid ? head[8:1] : 8'h00;
   assign rx_axis_tlast  = rx_axis_tvalid ? head[0] : 1'b0;

   always_ff @(posedge clk156) begin
      if (push) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   always_ff @(posedge clk156) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk156) begin
      if (reset) begin
         state          <= HDR;
         remaining      <= '0;
         len_rem        <= '0;
         exp_seq        <= '0;
         seq_valid      <= 1'b0;
         frames_ok      <= '0;
         frames_dropped <= '0;
         hdr_err        <= '0;
         seq_err        <= '0;
      end else begin
         case (state)
            HDR: begin
               if (in_valid) begin
                  if (hdr_bad) begin
                     if (hdr_err != 16'hFFFF) hdr_err <= hdr_err + 16'd1;
                  end else begin
                     if (seq_valid && (hdr_seq != exp_seq) && (seq_err != 16'hFFFF)) begin
                        seq_err <= seq_err + 16'd1;
                     end
                     exp_seq   <= hdr_seq + 16'd1;
                     seq_valid <= 1'b1;
                     remaining <= hdr_beats;
                     len_rem   <= hdr_len[2:0];
                     if (fits) begin
                        state <= PAY;
                     end else begin
                        state <= DISC;
                        if (frames_dropped != 16'hFFFF) frames_dropped <= frames_dropped + 16'd1;
                     end
                  end
               end
            end
            PAY: begin
               if (in_valid) begin
                  remaining <= remaining - 13'd1;
                  if (last_beat) begin
                     state <= HDR;
                     if (frames_ok != 32'hFFFF_FFFF) frames_ok <= frames_ok + 32'd1;
                  end
               end
            end
            DISC: begin
               if (in_valid) begin
                  remaining <= remaining - 13'd1;
                  if (last_beat) state <= HDR;
               end
            end
            default: state <= HDR;
         endcase
      end
   end

   // Space is reserved when a header is accepted, so a push can never meet a full FIFO.
   assert property (@(posedge clk156) disable iff (reset) !(push && (count == DEPTH_C)));

endmodule
